// File: rtl/panel_loader.sv
// Front-panel register loader: debounced deposit button drives a
// clear / gap / set / done pulse sequence onto target flip-flop clr/set pins.
// Optional readback compare enabled by defining PANEL_LOADER_READBACK_EN.
module panel_loader #(
    parameter int WIDTH           = 12,
    parameter int PULSE_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_deposit,
`ifdef PANEL_LOADER_READBACK_EN
    input  logic [WIDTH-1:0] reg_q,
    output logic             mismatch,
`endif
    output logic [WIDTH-1:0] reg_clr,
    output logic [WIDTH-1:0] reg_set,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PULSE_CYCLES - 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GAP,
        SET,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    pcnt;
    logic [DW-1:0]    db_cnt;
    logic             db_level;
    logic             db_prev;
    logic             db_rise;
    logic [WIDTH-1:0] word;

    assign db_rise = db_level & ~db_prev;

    // Debounce: the level flips only after a full run of disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sw_deposit == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DMAX) begin
                db_level <= sw_deposit;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Load sequencer with registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pcnt    <= '0;
            word    <= '0;
            reg_clr <= '0;
            reg_set <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (db_rise) begin
                        word    <= sw_data;
                        pcnt    <= '0;
                        reg_clr <= '1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (pcnt == PMAX) begin
                        pcnt    <= '0;
                        reg_clr <= '0;
                        state   <= GAP;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                GAP: begin
                    pcnt    <= '0;
                    reg_set <= word;
                    state   <= SET;
                end
                SET: begin
                    if (pcnt == PMAX) begin
                        pcnt    <= '0;
                        reg_set <= '0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                DONE: begin
                    pcnt  <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    pcnt    <= '0;
                    reg_clr <= '0;
                    reg_set <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef PANEL_LOADER_READBACK_EN
    // Sticky readback flag: checked in DONE, cleared as the next load starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (state == IDLE && db_rise) begin
            mismatch <= 1'b0;
        end else if (state == DONE && reg_q != word) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_panel_loader.sv
// Self-checking bench for panel_loader: table of clean loads plus bounce,
// mid-sequence re-press, reset-abort and optional readback sequences.
module tb_panel_loader;

    localparam int W   = 12;
    localparam int LAT = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_data;
    logic         sw_deposit;
    logic [W-1:0] reg_clr;
    logic [W-1:0] reg_set;
    logic         busy;
    logic         done;
`ifdef PANEL_LOADER_READBACK_EN
    logic [W-1:0] reg_q;
    logic         mismatch;
`endif

    panel_loader #(
        .WIDTH(W),
        .PULSE_CYCLES(4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_data(sw_data),
        .sw_deposit(sw_deposit),
`ifdef PANEL_LOADER_READBACK_EN
        .reg_q(reg_q),
        .mismatch(mismatch),
`endif
        .reg_clr(reg_clr),
        .reg_set(reg_set),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] clr;
        logic [W-1:0] set;
        logic         done;
    } out_t;

    typedef struct {
        logic [W-1:0] data;
        int           hold;
        logic [W-1:0] exp_set;
    } vec_t;

    out_t exp_q[$];
    int   start_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic busy_d     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every busy cycle.
    always @(negedge clk) begin
        out_t e;
        check("no_overlap", 32'(reg_clr & reg_set), 32'd0);
        if (busy && !busy_d) begin
            if (start_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                check("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
            end
`ifdef PANEL_LOADER_READBACK_EN
            check("mismatch_clr", 32'(mismatch), 32'd0);
`endif
        end
        if (busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_busy", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("clr", 32'(reg_clr), 32'(e.clr));
                check("set", 32'(reg_set), 32'(e.set));
                check("done", 32'(done), 32'(e.done));
            end
        end else begin
            check("idle_clr", 32'(reg_clr), 32'd0);
            check("idle_set", 32'(reg_set), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        busy_d = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_load(input logic [W-1:0] w, input int nset,
                             input bit with_done);
        for (int i = 0; i < 4; i++) exp_q.push_back('{'1, '0, 1'b0});
        exp_q.push_back('{'0, '0, 1'b0});
        for (int i = 0; i < nset; i++) exp_q.push_back('{'0, w, 1'b0});
        if (with_done) exp_q.push_back('{'0, '0, 1'b1});
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic press_and_load(input logic [W-1:0] d,
                                  input logic [W-1:0] xs, input int hold);
        @(negedge clk);
        sw_data    = d;
        sw_deposit = 1'b1;
        start_q.push_back(cyc + LAT);
        push_load(xs, 4, 1'b1);
        tick(hold);
        sw_deposit = 1'b0;
        tick(20);
        wait_idle(50);
    endtask

    vec_t vecs[6];

    initial begin
        int c;
        vecs = '{
            '{12'hA5C, 40, 12'hA5C},
            '{12'hFFF, 40, 12'hFFF},
            '{12'h000, 40, 12'h000},
            '{12'h001, 60, 12'h001},
            '{12'h800, 40, 12'h800},
            '{12'h5A3, 80, 12'h5A3}
        };
        rst        = 1'b1;
        sw_data    = '0;
        sw_deposit = 1'b0;
`ifdef PANEL_LOADER_READBACK_EN
        reg_q      = '0;
`endif
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_clr", 32'(reg_clr), 32'd0);
        check("rst_set", 32'(reg_set), 32'd0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++)
            press_and_load(vecs[i].data, vecs[i].exp_set, vecs[i].hold);

        // Bouncing contact, then a stable press.
        @(negedge clk);
        sw_data = 12'h3A7;
        for (int k = 0; k < 10; k++) begin
            sw_deposit = (k % 2 == 0);
            tick(3);
        end
        sw_deposit = 1'b1;
        start_q.push_back(cyc + LAT);
        push_load(12'h3A7, 4, 1'b1);
        tick(40);
        sw_deposit = 1'b0;
        tick(20);
        wait_idle(50);

        // Re-press while busy and data change in the middle of SET.
        @(negedge clk);
        sw_data    = 12'hA5C;
        sw_deposit = 1'b1;
        c = cyc;
        start_q.push_back(c + LAT);
        push_load(12'hA5C, 4, 1'b1);
        tick(18);
        sw_deposit = 1'b0;
        tick(2);
        sw_deposit = 1'b1;
        tick(3);
        sw_data = 12'h000;
        tick(30);
        sw_deposit = 1'b0;
        tick(20);
        wait_idle(50);

        // Reset during the second SET cycle, button still held.
        @(negedge clk);
        sw_data    = 12'h3C3;
        sw_deposit = 1'b1;
        c = cyc;
        start_q.push_back(c + LAT);
        push_load(12'h3C3, 2, 1'b0);
        tick(LAT + 6);
        rst = 1'b1;
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_set", 32'(reg_set), 32'd0);
        rst = 1'b0;
        start_q.push_back(cyc + LAT);
        push_load(12'h3C3, 4, 1'b1);
        tick(40);
        sw_deposit = 1'b0;
        tick(20);
        wait_idle(50);

`ifdef PANEL_LOADER_READBACK_EN
        reg_q = 12'hA58;
        press_and_load(12'hA5C, 12'hA5C, 40);
        check("mismatch_set", 32'(mismatch), 32'd1);
        reg_q = 12'h5A5;
        press_and_load(12'h5A5, 12'h5A5, 40);
        check("mismatch_ok", 32'(mismatch), 32'd0);
`endif

        tick(5);
        check("starts_left", 32'(start_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/panel_loader.md
PANEL_LOADER -- requirements
Module: panel_loader

Interface
REQ-001 Parameter WIDTH, default 12: register width loaded from the front-panel switches.
REQ-002 Parameter PULSE_CYCLES, default 4: width in clk cycles of each clear and set pulse; legal range >= 1.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stable samples required to accept a deposit-button change; legal range >= 1.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 sw_data  input  WIDTH  front-panel data switches; 1 = bit to be set.
REQ-007 sw_deposit  input  1  raw deposit pushbutton; 1 = pressed, may bounce.
REQ-008 reg_clr  output  WIDTH  per-bit active-high clear, driven to target flip-flop clr inputs.
REQ-009 reg_set  output  WIDTH  per-bit active-high set, driven to target flip-flop set inputs.
REQ-010 busy  output  1  high while a load sequence is in progress.
REQ-011 done  output  1  one-cycle pulse marking completion of a load.

Function
REQ-012 Debounce: sw_deposit SHALL be sampled every cycle; debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; any agreeing sample resets the count to 0.
REQ-013 A load SHALL start only on a 0->1 transition of the debounced level while in IDLE; transitions seen in any other state are discarded, not queued.
REQ-014 Start: in the cycle after the debounced rising edge, sw_data SHALL be latched into an internal word and the FSM enters CLEAR.
REQ-015 States: IDLE -> CLEAR (PULSE_CYCLES cycles) -> GAP (1 cycle) -> SET (PULSE_CYCLES cycles) -> DONE (1 cycle) -> IDLE.
REQ-016 CLEAR: reg_clr = all ones, reg_set = 0.
REQ-017 GAP: reg_clr = 0, reg_set = 0 (break-before-make).
REQ-018 SET: reg_set = latched word, reg_clr = 0.
REQ-019 DONE: reg_clr = 0, reg_set = 0, done = 1; done SHALL be 0 in every other state.
REQ-020 busy SHALL be 1 in CLEAR, GAP, SET and DONE, and 0 in IDLE; busy length = 2*PULSE_CYCLES+2 cycles.
REQ-021 For any bit i, reg_clr[i] and reg_set[i] SHALL never both be 1 in the same cycle.
REQ-022 sw_data changes after the latch cycle SHALL not affect reg_set during the sequence.
REQ-023 Pulse counter SHALL be sized to hold PULSE_CYCLES-1 and reload to 0 on each state entry.
REQ-024 Button held across DONE SHALL NOT retrigger; a new load requires debounced release then press.

Reset
REQ-025 While rst = 1 at a clk edge: state = IDLE, reg_clr = 0, reg_set = 0, busy = 0, done = 0, latched word = 0, counters = 0, debounced level = 0.
REQ-026 rst asserted mid-sequence SHALL abort the sequence with all outputs 0 from the following cycle, leaving target bits in their partially loaded state.
REQ-027 After reset deassertion, a button already held SHALL only start a load once it has debounced to 1 (rising edge from reset level 0).

Configuration
REQ-028 Macro PANEL_LOADER_READBACK_EN, when defined, SHALL add input reg_q (WIDTH, target flip-flop q outputs) and output mismatch (1).
REQ-029 With PANEL_LOADER_READBACK_EN: in DONE, reg_q is compared to the latched word; mismatch is set to 1 on inequality, held until the next load enters CLEAR or rst, and reset to 0.
REQ-030 Without PANEL_LOADER_READBACK_EN: neither port exists and no comparison logic is built; all other behaviour is identical.

Verification (WIDTH=12, PULSE_CYCLES=4, DEBOUNCE_CYCLES=16)
REQ-031 sw_data=12'hA5C, clean press held 40 cycles -> reg_clr=12'hFFF for 4 cycles, 1 gap cycle, reg_set=12'hA5C for 4 cycles, done high 1 cycle, busy high 10 cycles.
REQ-032 sw_deposit toggles every 3 cycles for 30 cycles, then settles at 1 -> exactly one load, starting after 16 stable high samples.
REQ-033 Second press issued during busy, sw_data changed to 12'h000 mid-SET -> reg_set stays 12'hA5C; no second load.
REQ-034 rst pulsed during the 2nd SET cycle -> reg_set/reg_clr/busy = 0 next cycle; no done pulse.
REQ-035 Every cycle of all tests -> (reg_clr & reg_set) == 0.
REQ-036 Readback enabled, reg_q tied to 12'hA58 while loading 12'hA5C -> mismatch = 1 after DONE, cleared when the next load enters CLEAR.
